// File: rtl/scale_factor_adapt.sv
// ADPCM quantizer scale-factor adaptation: FILTD/LIMB/FILTE update of YU/YL, then serial MIX to Y.
// Optional `define SFA_LIMFLAG_EN adds the lim_hit pulse output.
module scale_factor_adapt #(
    parameter int MUL_BITS = 7
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [11:0]         wi,
    input  logic [MUL_BITS-1:0] al,
    input  logic                wi_valid,
    output logic                wi_ready,
    output logic [12:0]         y,
    output logic                y_valid,
    output logic [12:0]         yu,
    output logic [18:0]         yl
`ifdef SFA_LIMFLAG_EN
    ,
    output logic                lim_hit
`endif
);

    localparam int ACC_W = 13 + MUL_BITS;
    localparam int CNT_W = (MUL_BITS > 1) ? $clog2(MUL_BITS) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FILT,
        S_LOAD,
        S_MUL,
        S_DONE
    } state_t;

    state_t              r_state;
    logic [11:0]         r_wi;
    logic [MUL_BITS-1:0] r_al;
    logic [12:0]         r_yu;
    logic [18:0]         r_yl;
    logic [12:0]         r_y;
    logic                r_difs;
    logic [ACC_W-1:0]    r_mcand;
    logic [ACC_W-1:0]    r_acc;
    logic [CNT_W-1:0]    r_cnt;
    logic                r_y_valid;
    logic                r_wi_ready;
`ifdef SFA_LIMFLAG_EN
    logic                r_lim_hit;
`endif

    // LIMB: keep the fast scale factor inside [544, 5120].
    function automatic logic [12:0] f_limb(input logic [12:0] yut);
        if (yut < 13'd544)
            return 13'd544;
        else if (yut >= 13'd5120)
            return 13'd5120;
        else
            return yut;
    endfunction

    logic [11:0] w_dif_hi;
    logic [12:0] w_difsx;
    logic [12:0] w_yut;
    logic [12:0] w_yup;
    logic [13:0] w_yl_inv;
    logic [13:0] w_fe_d;
    logic [18:0] w_ylp;
    logic [13:0] w_mix_d;
    logic [12:0] w_difm;
    logic [12:0] w_prodm;
    logic [12:0] w_prod;
    logic [12:0] w_ynew;

    // x>>5 of (32*wi - y) and (2^20 - yl)>>6 are formed directly as differences of ceilings
    assign w_dif_hi = r_wi - {4'd0, r_y[12:5]} - {11'd0, |r_y[4:0]};
    assign w_difsx  = {w_dif_hi[11], w_dif_hi};
    assign w_yut    = r_y + w_difsx;
    assign w_yup    = f_limb(w_yut);
    assign w_yl_inv = 14'd0 - {1'b0, r_yl[18:6]} - {13'd0, |r_yl[5:0]};
    assign w_fe_d   = {1'b0, w_yup} + w_yl_inv;
    assign w_ylp    = r_yl + {{5{w_fe_d[13]}}, w_fe_d};

    assign w_mix_d  = {1'b0, r_yu} - {1'b0, r_yl[18:6]};
    assign w_difm   = w_mix_d[13] ? (13'd0 - w_mix_d[12:0]) : w_mix_d[12:0];

    assign w_prodm  = 13'(r_acc >> 6);
    assign w_prod   = r_difs ? (13'd0 - w_prodm) : w_prodm;
    assign w_ynew   = r_yl[18:6] + w_prod;

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state    <= S_IDLE;
            r_wi       <= '0;
            r_al       <= '0;
            r_yu       <= 13'd544;
            r_yl       <= 19'd34816;
            r_y        <= 13'd544;
            r_difs     <= 1'b0;
            r_mcand    <= '0;
            r_acc      <= '0;
            r_cnt      <= '0;
            r_y_valid  <= 1'b1;
            r_wi_ready <= 1'b1;
`ifdef SFA_LIMFLAG_EN
            r_lim_hit  <= 1'b0;
`endif
        end else begin
`ifdef SFA_LIMFLAG_EN
            r_lim_hit <= 1'b0;
`endif
            case (r_state)
                S_IDLE: begin
                    if (wi_valid) begin
                        r_wi       <= wi;
                        r_al       <= al;
                        r_wi_ready <= 1'b0;
                        r_y_valid  <= 1'b0;
                        r_state    <= S_FILT;
                    end
                end
                S_FILT: begin
                    r_yu    <= w_yup;
                    r_yl    <= w_ylp;
`ifdef SFA_LIMFLAG_EN
                    r_lim_hit <= (w_yup != w_yut);
`endif
                    r_state <= S_LOAD;
                end
                S_LOAD: begin
                    r_difs  <= w_mix_d[13];
                    r_mcand <= ACC_W'(w_difm);
                    r_acc   <= '0;
                    r_cnt   <= '0;
                    r_state <= S_MUL;
                end
                // one AL bit per cycle, LSB first; multiplicand shifts up alongside
                S_MUL: begin
                    if (r_al[0])
                        r_acc <= r_acc + r_mcand;
                    r_mcand <= r_mcand << 1;
                    r_al    <= r_al >> 1;
                    if (r_cnt == CNT_W'(MUL_BITS - 1))
                        r_state <= S_DONE;
                    else
                        r_cnt <= r_cnt + 1'b1;
                end
                S_DONE: begin
                    r_y        <= w_ynew;
                    r_y_valid  <= 1'b1;
                    r_wi_ready <= 1'b1;
                    r_state    <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign wi_ready = r_wi_ready;
    assign y        = r_y;
    assign y_valid  = r_y_valid;
    assign yu       = r_yu;
    assign yl       = r_yl;
`ifdef SFA_LIMFLAG_EN
    assign lim_hit  = r_lim_hit;
`endif

endmodule
